mul_sequencer: RTL

//  Multi-cycle controller for the shared radix-2 shift-add multiplier in the multicycle ARM datapath.

---
 rtl/mul_sequencer.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/mul_sequencer.sv
// mul_sequencer
//   Multi-cycle controller for the shared radix-2 shift-add multiplier. It
//   executes MUL, MLA, UMULL and SMULL once the main control FSM has decoded a
//   multiply-class instruction. It sequences the optional accumulator read,
//   WIDTH shift-add iterations, the SMULL sign fix, and one or two writebacks.
//
// Ports
//   i_clk, i_reset      clock; synchronous active-high reset
//   i_start             launch request, sampled only while idle
//   i_op                00 MUL, 01 MLA, 10 UMULL, 11 SMULL (latched with start)
//   i_set_flags         S bit (latched with start)
//   i_src_a, i_src_b    multiplicand / multiplier (latched with start)
//   i_acc_rd            register-file read data for Ra, sampled in ACC_RD
//   o_acc_req           steers the read port to Ra (ACC_RD only)
//   o_busy              high from the cycle after accept through the done cycle
//   o_wr_en/o_wr_hi     write strobe and hi/lo select
//   o_wr_data           write data
//   o_flag_we/n/z       N/Z update, pulses with done when S was set
//   o_done              completion pulse, coincident with the final write
module mul_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [1:0]       i_op,
  input  logic             i_set_flags,
  input  logic [WIDTH-1:0] i_src_a,
  input  logic [WIDTH-1:0] i_src_b,
  input  logic [WIDTH-1:0] i_acc_rd,
  output logic             o_acc_req,
  output logic             o_busy,
  output logic             o_wr_en,
  output logic             o_wr_hi,
  output logic [WIDTH-1:0] o_wr_data,
  output logic             o_flag_we,
  output logic             o_flag_n,
  output logic             o_flag_z,
  output logic             o_done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ACC   = 3'd1;
  localparam logic [2:0] S_MULT  = 3'd2;
  localparam logic [2:0] S_FIX   = 3'd3;
  localparam logic [2:0] S_WB_LO = 3'd4;
  localparam logic [2:0] S_WB_HI = 3'd5;

  localparam logic [1:0] OP_MUL   = 2'b00;
  localparam logic [1:0] OP_MLA   = 2'b01;
  localparam logic [1:0] OP_SMULL = 2'b11;

  logic [2:0]         r_state;
  logic [1:0]         r_op;
  logic               r_sf;
  logic               r_neg;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_mcand;   // multiplicand, shifted left one place per iteration
  logic [WIDTH-1:0]   r_mplier;  // multiplier, current bit always at [0]
  logic [WIDTH-1:0]   r_acc;
  logic [2*WIDTH-1:0] r_prod;

  // SMULL runs the unsigned core on magnitudes and negates afterwards.
  // The magnitude of the most negative value is still correct read as unsigned.
  logic             w_smull;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;

  assign w_smull = (i_op == OP_SMULL);
  assign w_a_neg = w_smull & i_src_a[WIDTH-1];
  assign w_b_neg = w_smull & i_src_b[WIDTH-1];
  assign w_a_mag = w_a_neg ? (~i_src_a + WIDTH'(1)) : i_src_a;
  assign w_b_mag = w_b_neg ? (~i_src_b + WIDTH'(1)) : i_src_b;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= S_IDLE;
      r_op     <= OP_MUL;
      r_sf     <= 1'b0;
      r_neg    <= 1'b0;
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_prod   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_op     <= i_op;
            r_sf     <= i_set_flags;
            r_neg    <= w_a_neg ^ w_b_neg;
            r_mcand  <= {{WIDTH{1'b0}}, w_a_mag};
            r_mplier <= w_b_mag;
            r_prod   <= '0;
            r_cnt    <= '0;
            r_state  <= (i_op == OP_MLA) ? S_ACC : S_MULT;
          end
        end
        S_ACC: begin
          r_acc   <= i_acc_rd;
          r_state <= S_MULT;
        end
        S_MULT: begin
          // Always WIDTH iterations so latency never depends on operand values.
          if (r_mplier[0]) r_prod <= r_prod + r_mcand;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          if (r_cnt == CW'(WIDTH - 1)) begin
            r_cnt   <= '0;
            r_state <= (r_op == OP_SMULL) ? S_FIX : S_WB_LO;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_FIX: begin
          if (r_neg) r_prod <= ~r_prod + (2*WIDTH)'(1);
          r_state <= S_WB_LO;
        end
        S_WB_LO: r_state <= r_op[1] ? S_WB_HI : S_IDLE;
        S_WB_HI: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  logic             w_long;
  logic [WIDTH-1:0] w_lo;
  logic             w_res_zero;
  logic             w_res_msb;

  assign w_long     = r_op[1];
  // The accumulate is folded into the low writeback; it wraps modulo 2^WIDTH.
  assign w_lo       = r_prod[WIDTH-1:0] + ((r_op == OP_MLA) ? r_acc : '0);
  assign w_res_zero = w_long ? (r_prod == '0) : (w_lo == '0);
  assign w_res_msb  = w_long ? r_prod[2*WIDTH-1] : w_lo[WIDTH-1];

  // Outputs decode from state only, so every output is 0 while idle.
  assign o_busy    = (r_state != S_IDLE);
  assign o_acc_req = (r_state == S_ACC);
  assign o_wr_en   = (r_state == S_WB_LO) | (r_state == S_WB_HI);
  assign o_wr_hi   = (r_state == S_WB_HI);
  assign o_wr_data = (r_state == S_WB_HI) ? r_prod[2*WIDTH-1:WIDTH] :
                     (r_state == S_WB_LO) ? w_lo : '0;
  assign o_done    = ((r_state == S_WB_LO) & ~w_long) | (r_state == S_WB_HI);
  assign o_flag_we = o_done & r_sf;
  assign o_flag_n  = o_flag_we & w_res_msb;
  assign o_flag_z  = o_flag_we & w_res_zero;

endmodule
